// File: rtl/rv32i_lsu_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_lsu_mc_if
// Brief    : Request/response and word-aligned memory bundle for rv32i_lsu_mc.
// Revision : 1.0
// ============================================================================
interface rv32i_lsu_mc_if #(
    parameter int XLEN = 32
);
    localparam int BYTES = XLEN / 8;

    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    logic [2:0]       req_funct3;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_wdata;
    logic             resp_valid;
    logic [XLEN-1:0]  resp_rdata;
    logic             resp_misaligned;
    logic             resp_illegal;
    logic             resp_timeout;
    logic             mem_read;
    logic             mem_write;
    logic [XLEN-1:0]  mem_address;
    logic [XLEN-1:0]  mem_wdata;
    logic [BYTES-1:0] mem_byte_enable;
    logic [XLEN-1:0]  mem_rdata;
    logic             mem_resp;

    // The load/store unit itself
    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  mem_rdata, mem_resp,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
        output resp_illegal, resp_timeout,
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );

    // Control plus memory surrounding the unit
    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output mem_rdata, mem_resp,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
        input  resp_illegal, resp_timeout,
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_lsu_mc.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_lsu_mc
// Brief    : Multicycle RV32I/RV64I load/store unit with lane masking,
//            load extension, fault detection and memory timeout.
// Revision : 1.0
// ============================================================================
module rv32i_lsu_mc #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 0,
    parameter int CNTW    = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    rv32i_lsu_mc_if.slave   lsu
);
    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam logic [CNTW-1:0] c_to_last = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_store, w_store_nxt;
    logic [2:0]       r_f3, w_f3_nxt;
    logic [OFFW-1:0]  r_off, w_off_nxt;
    logic [CNTW-1:0]  r_cnt, w_cnt_nxt;
    logic             r_rd, w_rd_nxt;
    logic             r_wr, w_wr_nxt;
    logic [XLEN-1:0]  r_addr, w_addr_nxt;
    logic [XLEN-1:0]  r_wdata, w_wdata_nxt;
    logic [BYTES-1:0] r_be, w_be_nxt;
    logic             r_rvalid, w_rvalid_nxt;
    logic [XLEN-1:0]  r_rdata, w_rdata_nxt;
    logic             r_mis, w_mis_nxt;
    logic             r_ill, w_ill_nxt;
    logic             r_to, w_to_nxt;

    logic [OFFW-1:0]  w_off;
    logic             w_illegal;
    logic             w_misaligned;
    logic [BYTES-1:0] w_size_mask;
    logic [BYTES-1:0] w_be;
    logic [XLEN-1:0]  w_wshift;
    logic [XLEN-1:0]  w_raw;
    logic [6:0]       w_sh;
    logic [XLEN-1:0]  w_left;
    logic [XLEN-1:0]  w_zext;
    logic signed [XLEN-1:0] w_sext;
    logic [XLEN-1:0]  w_ext;

    // Request decode, only meaningful while IDLE
    always_comb begin
        w_off = lsu.req_addr[OFFW-1:0];
        case (lsu.req_funct3)
            3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
            3'b011:                 w_illegal = (XLEN != 64);
            3'b100, 3'b101:         w_illegal = lsu.req_store;
            3'b110:                 w_illegal = lsu.req_store || (XLEN != 64);
            default:                w_illegal = 1'b1;
        endcase
        case (lsu.req_funct3[1:0])
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = lsu.req_addr[0];
            2'd2:    w_misaligned = |lsu.req_addr[1:0];
            default: w_misaligned = |lsu.req_addr[2:0];
        endcase
        case (lsu.req_funct3[1:0])
            2'd0:    w_size_mask = BYTES'(1);
            2'd1:    w_size_mask = BYTES'(3);
            2'd2:    w_size_mask = BYTES'(15);
            default: w_size_mask = BYTES'(255);
        endcase
        w_be     = w_size_mask << w_off;
        w_wshift = lsu.req_wdata << {w_off, 3'b000};
    end

    // Load extraction: left-justify the field, then shift back logically or arithmetically
    always_comb begin
        w_raw  = lsu.mem_rdata >> {r_off, 3'b000};
        w_sh   = 7'(XLEN) - (7'd8 << r_f3[1:0]);
        w_left = w_raw << w_sh;
        w_zext = w_left >> w_sh;
        w_sext = $signed(w_left) >>> w_sh;
        w_ext  = r_f3[2] ? w_zext : $unsigned(w_sext);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_store_nxt  = r_store;
        w_f3_nxt     = r_f3;
        w_off_nxt    = r_off;
        w_cnt_nxt    = r_cnt;
        w_rd_nxt     = 1'b0;
        w_wr_nxt     = 1'b0;
        w_addr_nxt   = '0;
        w_wdata_nxt  = '0;
        w_be_nxt     = '0;
        w_rvalid_nxt = 1'b0;
        w_rdata_nxt  = '0;
        w_mis_nxt    = 1'b0;
        w_ill_nxt    = 1'b0;
        w_to_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (lsu.req_valid) begin
                    w_store_nxt = lsu.req_store;
                    w_f3_nxt    = lsu.req_funct3;
                    w_off_nxt   = w_off;
                    if (w_illegal) begin
                        w_state_nxt  = S_RESP;
                        w_rvalid_nxt = 1'b1;
                        w_ill_nxt    = 1'b1;
                    end else if (w_misaligned) begin
                        w_state_nxt  = S_RESP;
                        w_rvalid_nxt = 1'b1;
                        w_mis_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = S_ACCESS;
                        w_cnt_nxt   = '0;
                        w_rd_nxt    = ~lsu.req_store;
                        w_wr_nxt    = lsu.req_store;
                        w_addr_nxt  = {lsu.req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        w_wdata_nxt = lsu.req_store ? w_wshift : '0;
                        w_be_nxt    = lsu.req_store ? w_be : '1;
                    end
                end
            end
            S_ACCESS: begin
                if (lsu.mem_resp) begin
                    w_state_nxt  = S_RESP;
                    w_rvalid_nxt = 1'b1;
                    w_rdata_nxt  = r_store ? '0 : w_ext;
                end else if ((TIMEOUT != 0) && (r_cnt == c_to_last)) begin
                    w_state_nxt  = S_RESP;
                    w_rvalid_nxt = 1'b1;
                    w_to_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_rd_nxt    = r_rd;
                    w_wr_nxt    = r_wr;
                    w_addr_nxt  = r_addr;
                    w_wdata_nxt = r_wdata;
                    w_be_nxt    = r_be;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_store  <= 1'b0;
            r_f3     <= '0;
            r_off    <= '0;
            r_cnt    <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_mis    <= 1'b0;
            r_ill    <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_store  <= w_store_nxt;
            r_f3     <= w_f3_nxt;
            r_off    <= w_off_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rd     <= w_rd_nxt;
            r_wr     <= w_wr_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_be     <= w_be_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_rdata  <= w_rdata_nxt;
            r_mis    <= w_mis_nxt;
            r_ill    <= w_ill_nxt;
            r_to     <= w_to_nxt;
        end
    end

    assign lsu.req_ready       = (r_state == S_IDLE);
    assign lsu.resp_valid      = r_rvalid;
    assign lsu.resp_rdata      = r_rdata;
    assign lsu.resp_misaligned = r_mis;
    assign lsu.resp_illegal    = r_ill;
    assign lsu.resp_timeout    = r_to;
    assign lsu.mem_read        = r_rd;
    assign lsu.mem_write       = r_wr;
    assign lsu.mem_address     = r_addr;
    assign lsu.mem_wdata       = r_wdata;
    assign lsu.mem_byte_enable = r_be;
endmodule
`default_nettype wire

// File: tb/tb_rv32i_lsu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_lsu_mc
// Brief    : Randomized bench for rv32i_lsu_mc at XLEN=32 (TIMEOUT=4) and XLEN=64.
// Revision : 1.0
// ============================================================================
module tb_rv32i_lsu_mc;
    localparam int TO32 = 4;
    localparam int TO64 = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32i_lsu_mc_if #(.XLEN(32)) b32 ();
    rv32i_lsu_mc_if #(.XLEN(64)) b64 ();

    rv32i_lsu_mc #(.XLEN(32), .TIMEOUT(TO32), .CNTW(16)) dut32 (.clk(clk), .rst(rst), .lsu(b32));
    rv32i_lsu_mc #(.XLEN(64), .TIMEOUT(TO64), .CNTW(16)) dut64 (.clk(clk), .rst(rst), .lsu(b64));

    int n_checks = 0;
    int n_err    = 0;

    logic        s_ready, s_rvalid, s_mis, s_ill, s_to, s_rd, s_wr;
    logic [63:0] s_rdata, s_addr, s_wdata;
    logic [7:0]  s_be;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic smp(input bit w64);
        if (w64) begin
            s_ready = b64.req_ready;  s_rvalid = b64.resp_valid; s_rdata = b64.resp_rdata;
            s_mis = b64.resp_misaligned; s_ill = b64.resp_illegal; s_to = b64.resp_timeout;
            s_rd = b64.mem_read; s_wr = b64.mem_write; s_addr = b64.mem_address;
            s_wdata = b64.mem_wdata; s_be = b64.mem_byte_enable;
        end else begin
            s_ready = b32.req_ready;  s_rvalid = b32.resp_valid; s_rdata = {32'b0, b32.resp_rdata};
            s_mis = b32.resp_misaligned; s_ill = b32.resp_illegal; s_to = b32.resp_timeout;
            s_rd = b32.mem_read; s_wr = b32.mem_write; s_addr = {32'b0, b32.mem_address};
            s_wdata = {32'b0, b32.mem_wdata}; s_be = {4'b0, b32.mem_byte_enable};
        end
    endtask

    task automatic drv_req(input bit w64, input bit v, input bit st, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] wd);
        if (w64) begin
            b64.req_valid = v; b64.req_store = st; b64.req_funct3 = f3;
            b64.req_addr = a; b64.req_wdata = wd;
        end else begin
            b32.req_valid = v; b32.req_store = st; b32.req_funct3 = f3;
            b32.req_addr = a[31:0]; b32.req_wdata = wd[31:0];
        end
    endtask

    task automatic drv_mem(input bit w64, input bit r, input logic [63:0] d);
        if (w64) begin
            b64.mem_resp = r; b64.mem_rdata = d;
        end else begin
            b32.mem_resp = r; b32.mem_rdata = d[31:0];
        end
    endtask

    function automatic bit is_legal(input int xl, input bit st, input logic [2:0] f3);
        if (st) return (f3 inside {3'd0, 3'd1, 3'd2}) || (xl == 64 && f3 == 3'd3);
        return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (xl == 64 && f3 inside {3'd3, 3'd6});
    endfunction

    // Load result from the size/sign rules with plain wide arithmetic
    function automatic logic [63:0] ref_load(input int xl, input logic [2:0] f3,
                                             input logic [63:0] md, input int off);
        int           bits;
        logic [127:0] full;
        logic [127:0] raw;
        bits = 8 << f3[1:0];
        full = (128'(1) << bits) - 128'(1);
        raw  = (128'(md) >> (8 * off)) & full;
        if (!f3[2] && raw[bits-1]) raw = raw | ~full;
        return (xl == 32) ? {32'b0, raw[31:0]} : raw[63:0];
    endfunction

    task automatic run_txn(input bit w64, input bit st, input logic [2:0] f3,
                           input logic [63:0] a_in, input logic [63:0] wd_in,
                           input logic [63:0] md_in, input int dly);
        int          xl, nbyt, to, nb, off, fin;
        bit          ill, mis, exp_to;
        logic [63:0] a, wd, md, xmask, exp_addr, exp_wd, exp_rd;
        logic [7:0]  exp_be;
        xl    = w64 ? 64 : 32;
        nbyt  = xl / 8;
        to    = w64 ? TO64 : TO32;
        xmask = w64 ? '1 : 64'h0000_0000_FFFF_FFFF;
        a     = a_in & xmask;
        wd    = wd_in & xmask;
        md    = md_in & xmask;
        nb    = 1 << f3[1:0];
        off   = int'(a % 64'(nbyt));
        ill   = !is_legal(xl, st, f3);
        mis   = (a % 64'(nb)) != 0;
        exp_addr = a & ~64'(nbyt - 1);
        exp_be   = st ? 8'(((1 << nb) - 1) << off) : 8'((1 << nbyt) - 1);
        exp_wd   = (wd << (8 * off)) & xmask;

        smp(w64);
        check_val("ready_before_req", 64'(s_ready), 64'd1);
        drv_req(w64, 1'b1, st, f3, a, wd);
        @(posedge clk); #1;
        drv_req(w64, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        smp(w64);
        if (ill || mis) begin
            check_val("fault_rvalid", 64'(s_rvalid), 64'd1);
            check_val("fault_illegal", 64'(s_ill), 64'(ill));
            check_val("fault_misaligned", 64'(s_mis && !ill), 64'(mis && !ill));
            check_val("fault_mis_suppressed", 64'(s_mis && ill), 64'd0);
            check_val("fault_timeout", 64'(s_to), 64'd0);
            check_val("fault_mem_rw", {62'd0, s_rd, s_wr}, 64'd0);
            check_val("fault_rdata", s_rdata, 64'd0);
        end else begin
            fin    = (dly != 0 && (to == 0 || dly <= to)) ? dly : to;
            exp_to = (fin != dly);
            exp_rd = (st || exp_to) ? 64'd0 : ref_load(xl, f3, md, off);
            for (int k = 1; k <= fin; k++) begin
                if (k > 1) smp(w64);
                check_val("access_rvalid", 64'(s_rvalid), 64'd0);
                check_val("access_rd_wr", {62'd0, s_rd, s_wr}, {62'd0, !st, st});
                check_val("access_addr", s_addr, exp_addr);
                check_val("access_be", 64'(s_be), 64'(exp_be));
                if (st) check_val("access_wdata", s_wdata, exp_wd);
                if (k == dly) drv_mem(w64, 1'b1, md);
                else          drv_mem(w64, 1'b0, {$urandom, $urandom});
                @(posedge clk); #1;
                drv_mem(w64, 1'b0, 64'd0);
            end
            smp(w64);
            check_val("resp_rvalid", 64'(s_rvalid), 64'd1);
            check_val("resp_rdata", s_rdata, exp_rd);
            check_val("resp_timeout", 64'(s_to), 64'(exp_to));
            check_val("resp_faults", {62'd0, s_mis, s_ill}, 64'd0);
            check_val("resp_mem_rw", {62'd0, s_rd, s_wr}, 64'd0);
        end
        @(posedge clk); #1;
        smp(w64);
        check_val("after_rvalid", 64'(s_rvalid), 64'd0);
        check_val("after_ready", 64'(s_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] ra;
        bit          w64;
        bit          st;
        logic [2:0]  f3;
        int          dly;
        drv_req(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        drv_req(1'b1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        drv_mem(1'b0, 1'b0, 64'd0);
        drv_mem(1'b1, 1'b0, 64'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 2; w++) begin
            smp(w[0]);
            check_val("reset_ready", 64'(s_ready), 64'd1);
            check_val("reset_outputs", {s_rvalid, s_mis, s_ill, s_to, s_rd, s_wr} | s_rdata | s_addr | s_wdata | 64'(s_be), 64'd0);
        end
        rst = 1'b0;

        run_txn(1'b0, 1'b0, 3'b100, 64'h103, 64'd0, 64'h80FF1234, 1);
        run_txn(1'b0, 1'b0, 3'b001, 64'h102, 64'd0, 64'h80FF1234, 1);
        run_txn(1'b0, 1'b1, 3'b000, 64'h201, 64'hAB, 64'd0, 1);
        run_txn(1'b0, 1'b0, 3'b010, 64'h102, 64'd0, 64'h1, 1);
        run_txn(1'b0, 1'b0, 3'b011, 64'h100, 64'd0, 64'h1, 1);
        run_txn(1'b0, 1'b0, 3'b111, 64'h101, 64'd0, 64'h1, 1);
        run_txn(1'b0, 1'b0, 3'b010, 64'h100, 64'd0, 64'h1234, 0);
        run_txn(1'b0, 1'b0, 3'b010, 64'h100, 64'd0, 64'h89AB_CDEF, 4);
        run_txn(1'b1, 1'b0, 3'b010, 64'h4, 64'd0, 64'h80000001_12345678, 1);
        run_txn(1'b1, 1'b0, 3'b110, 64'h4, 64'd0, 64'h80000001_12345678, 2);
        run_txn(1'b1, 1'b1, 3'b011, 64'h8, 64'hDEAD_BEEF_0123_4567, 64'd0, 3);

        // Reset while a load is outstanding, then a stale memory response
        drv_req(1'b0, 1'b1, 1'b0, 3'b010, 64'h100, 64'd0);
        @(posedge clk); #1;
        drv_req(1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
        smp(1'b0);
        check_val("rstmid_pre_rd", 64'(s_rd), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        smp(1'b0);
        check_val("rstmid_rd", 64'(s_rd), 64'd0);
        check_val("rstmid_ready", 64'(s_ready), 64'd1);
        drv_mem(1'b0, 1'b1, 64'h5555_5555);
        @(posedge clk); #1;
        drv_mem(1'b0, 1'b0, 64'd0);
        for (int k = 0; k < 3; k++) begin
            smp(1'b0);
            check_val("rstmid_no_resp", 64'(s_rvalid), 64'd0);
            check_val("rstmid_ready_hold", 64'(s_ready), 64'd1);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 300; i++) begin
            w64 = $urandom_range(0, 1) == 1;
            st  = $urandom_range(0, 2) == 0;
            f3  = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) ra[2:0] = 3'd0;
            if (w64) dly = $urandom_range(1, 3);
            else     dly = $urandom_range(0, 6);
            run_txn(w64, st, f3, ra, {$urandom, $urandom}, {$urandom, $urandom}, dly);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
